// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, sequencer state encoding and default program depth.
package alu_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 12;

  typedef enum logic [3:0] {
    OpNop = 4'd0,
    OpLdi = 4'd1,
    OpAdd = 4'd2,
    OpSub = 4'd3,
    OpNot = 4'd4,
    OpAnd = 4'd5,
    OpIor = 4'd6,
    OpXor = 4'd7,
    OpShl = 4'd8,
    OpShr = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    StReset,
    StIdle,
    StRun,
    StDone,
    StError
  } state_e;

  // Codes above SHR are reserved and treated as illegal.
  function automatic logic op_valid(input logic [3:0] op);
    return op <= 4'(OpShr);
  endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module alu_prog_mem #(
  parameter int unsigned DEPTH = alu_pkg::DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   wen,
  input  logic [AW-1:0]          waddr,
  input  logic [alu_pkg::IW-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [alu_pkg::IW-1:0] rdata
);

  logic [alu_pkg::IW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues a stored ALU program one instruction per cycle, honouring a downstream hold.
module alu_sequencer #(
  parameter int unsigned DEPTH = alu_pkg::DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   prog_wen,
  input  logic [AW-1:0]          prog_addr,
  input  logic [alu_pkg::IW-1:0] prog_data,
  input  logic                   start,
  input  logic [CW-1:0]          len,
  input  logic                   hold,
  output logic [alu_pkg::IW-1:0] inst,
  output logic                   inst_wen,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [AW-1:0]          pc
);

  import alu_pkg::*;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          first_q, first_d;
  logic [IW-1:0] first_inst_q, first_inst_d;
  logic          busy_q, done_q, error_q;

  logic [IW-1:0] rd_data;
  logic [IW-1:0] cur_inst;
  logic          run;
  logic          mem_wen;
  logic          bad_op;

  assign run     = (state_q == StRun);
  assign mem_wen = prog_wen && ((state_q == StIdle) || (state_q == StDone));

  // Outside Run the read port looks at slot 0 so start can snapshot it before a same-cycle write.
  alu_prog_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clock(clock),
    .wen  (mem_wen),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(run ? pc_q : '0),
    .rdata(rd_data)
  );

  assign cur_inst = first_q ? first_inst_q : rd_data;
  assign bad_op   = !op_valid(cur_inst[11:8]);
  assign inst     = run ? cur_inst : '0;
  assign inst_wen = run && !hold && !bad_op;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign pc       = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    first_d      = first_q;
    first_inst_d = first_inst_q;
    case (state_q)
      StReset: state_d = StIdle;
      StIdle, StDone: begin
        if (start) begin
          if (len == '0) begin
            state_d = StDone;
          end else if (len > CW'(DEPTH)) begin
            state_d = StError;
          end else begin
            state_d      = StRun;
            pc_d         = '0;
            count_d      = len;
            first_d      = 1'b1;
            first_inst_d = rd_data;
          end
        end
      end
      StRun: begin
        if (!hold) begin
          if (bad_op) begin
            state_d = StError;
          end else begin
            pc_d    = pc_q + 1'b1;
            count_d = count_q - 1'b1;
            first_d = 1'b0;
            if (count_q == CW'(1)) begin
              state_d = StDone;
            end
          end
        end
      end
      StError: state_d = StError;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StReset;
      pc_q         <= '0;
      count_q      <= '0;
      first_q      <= 1'b0;
      first_inst_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      first_q      <= first_d;
      first_inst_q <= first_inst_d;
      busy_q       <= (state_d == StRun);
      done_q       <= (state_d == StDone);
      error_q      <= (state_d == StError);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random programs against a slot-list model.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        prog_wen = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        hold = 1'b0;
  logic [11:0] inst;
  logic        inst_wen;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  pc;

  int total = 0;
  int bad = 0;

  logic [11:0] mem_m [16];
  logic [11:0] iss_q [$];

  alu_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .prog_wen (prog_wen),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .start    (start),
    .len      (len),
    .hold     (hold),
    .inst     (inst),
    .inst_wen (inst_wen),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .pc       (pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [11:0] w);
    logic [7:0] i;
    i = w[7:0];
    case (w[11:8])
      4'd1:    return i;
      4'd2:    return a + i;
      4'd3:    return a - i;
      4'd4:    return ~a;
      4'd5:    return a & i;
      4'd6:    return a | i;
      4'd7:    return a ^ i;
      4'd8:    return a << i;
      4'd9:    return a >> i;
      default: return a;
    endcase
  endfunction

  task automatic write_slot(input int a, input logic [11:0] d);
    @(negedge clock);
    prog_wen  = 1'b1;
    prog_addr = 4'(a);
    prog_data = d;
    @(negedge clock);
    prog_wen  = 1'b0;
    mem_m[a]  = d;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_inst_wen"}, inst_wen, 0);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_quiet("rst");
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pc", pc, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // outcome: 1 = finished in Done, 2 = stopped in Error
  task automatic run_prog(input int n, input int hold_pct, input int hold_after, output int outcome);
    int k;
    int hold_left;
    bit hold_used;
    bit ok;
    k = 0;
    hold_left = 0;
    hold_used = 0;
    outcome = 0;
    iss_q.delete();
    @(negedge clock);
    start = 1'b1;
    len   = 5'(n);
    hold  = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_used && iss_q.size() == hold_after) begin
        hold_left = 2;
        hold_used = 1;
      end
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
      end else begin
        hold = ($urandom_range(0, 99) < hold_pct);
      end
      #1;
      ok = (mem_m[k][11:8] <= 4'd9);
      chk("run_busy", busy, 1);
      chk("run_inst", inst, mem_m[k]);
      chk("run_inst_wen", inst_wen, !hold && ok);
      chk("run_pc", pc, k);
      if (inst_wen) iss_q.push_back(inst);
      if (!hold) begin
        if (!ok) begin
          outcome = 2;
        end else begin
          k++;
          if (k == n) outcome = 1;
        end
      end
      @(negedge clock);
      if (outcome != 0) break;
    end
    hold = 1'b0;
    #1;
    if (outcome == 0) chk("run_timeout", busy, 0);
    chk("end_done", done, outcome == 1);
    chk("end_error", error, outcome == 2);
    chk("end_pc", pc, k % 16);
    chk("end_issues", iss_q.size(), k);
    check_quiet("end");
  endtask

  initial begin
    int outcome;
    logic [7:0] acc;
    logic [11:0] w;
    int j;

    // Reset state
    #1;
    check_quiet("por");
    chk("por_done", done, 0);
    chk("por_error", error, 0);
    chk("por_pc", pc, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 16; i++) write_slot(i, {4'($urandom_range(0, 9)), 8'($urandom)});

    // Basic program and ALU result
    write_slot(0, 12'h105);
    write_slot(1, 12'h203);
    write_slot(2, 12'h801);
    write_slot(3, 12'h902);
    run_prog(4, 0, -1, outcome);
    acc = '0;
    foreach (iss_q[i]) acc = alu_ref(acc, iss_q[i]);
    chk("alu_result", acc, 8'h04);

    // Two-cycle hold after the second issue
    run_prog(4, 0, 2, outcome);
    chk("hold_issues", iss_q.size(), 4);

    // Start and write to slot 0 in the same cycle: old word is issued first
    w = mem_m[0];
    @(negedge clock);
    start = 1'b1; len = 5'd1;
    prog_wen = 1'b1; prog_addr = 4'd0; prog_data = 12'h1AA;
    @(negedge clock);
    start = 1'b0; prog_wen = 1'b0;
    #1;
    chk("sim_inst", inst, w);
    chk("sim_inst_wen", inst_wen, 1);
    mem_m[0] = 12'h1AA;
    @(negedge clock);
    #1;
    chk("sim_done", done, 1);
    run_prog(1, 0, -1, outcome);
    chk("sim_newword", iss_q[0], 12'h1AA);

    // len = 0 and len = 17
    @(negedge clock);
    start = 1'b1; len = 5'd0;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("len0_done", done, 1);
    check_quiet("len0");
    @(negedge clock);
    start = 1'b1; len = 5'd17;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("len17_error", error, 1);
    check_quiet("len17");
    do_reset();

    // Invalid opcode at slot 1, sticky error, writes blocked in Error
    write_slot(1, 12'hA00);
    run_prog(3, 0, -1, outcome);
    chk("inv_pc", pc, 1);
    for (int p = 0; p < 2; p++) begin
      @(negedge clock);
      start = 1'b1; len = 5'd2;
      prog_wen = 1'b1; prog_addr = 4'd1; prog_data = 12'h105;
      @(negedge clock);
      start = 1'b0; prog_wen = 1'b0;
      #1;
      chk("sticky_error", error, 1);
      chk("sticky_busy", busy, 0);
    end
    do_reset();
    run_prog(3, 0, -1, outcome);
    chk("err_write_blocked", error, 1);
    do_reset();
    write_slot(1, 12'h203);

    // Reset mid-run; writes during Run and during Reset are ignored
    @(negedge clock);
    start = 1'b1; len = 5'd8;
    @(negedge clock);
    start = 1'b0;
    prog_wen = 1'b1; prog_addr = 4'd5; prog_data = mem_m[5] ^ 12'h0FF;
    #1;
    chk("mr_pc0", pc, 0);
    @(negedge clock);
    prog_wen = 1'b0;
    #1;
    chk("mr_pc1", pc, 1);
    @(negedge clock);
    #1;
    chk("mr_pc2", pc, 2);
    chk("mr_wen_before", inst_wen, 1);
    reset = 1'b1;
    #1;
    check_quiet("mr_async");
    chk("mr_pc_rst", pc, 0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1; len = 5'd1;
    prog_wen = 1'b1; prog_addr = 4'd6; prog_data = mem_m[6] ^ 12'h0FF;
    @(negedge clock);
    start = 1'b0; prog_wen = 1'b0;
    #1;
    check_quiet("mr_idle");
    chk("mr_idle_done", done, 0);
    run_prog(16, 0, -1, outcome);
    chk("mr_slot5", iss_q[5], mem_m[5]);
    chk("mr_slot6", iss_q[6], mem_m[6]);

    // Random programs with random holds, occasionally containing an illegal opcode
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) write_slot(i, {4'($urandom_range(0, 9)), 8'($urandom)});
      if (r % 3 == 2) begin
        j = $urandom_range(0, 15);
        write_slot(j, {4'($urandom_range(10, 15)), 8'($urandom)});
      end
      run_prog($urandom_range(1, 16), 30, -1, outcome);
      if (outcome == 2) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
